// File: rtl/ntt_pkg.sv
// Shared constants and types for the 256-point NTT sequencer.
// Holds the layer/butterfly counts, the FSM state type and the write-back delay-line entry.
package ntt_pkg;

  localparam int N            = 256;
  localparam int LOGN         = 8;
  localparam int NUM_LAYERS   = 7;
  localparam int BF_PER_LAYER = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ntt_state_t;

  // One write-back delay-line entry: the E/O addresses plus a valid bit.
  typedef struct packed {
    logic [LOGN-1:0] a;
    logic [LOGN-1:0] b;
    logic            v;
  } wb_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address generator.
// Forward layers shrink the butterfly span from 128 to 2; inverse layers grow it from 2 to 128.
module ntt_addr_gen
  import ntt_pkg::*;
(
  input  logic            mode,
  input  logic [2:0]      layer,
  input  logic [6:0]      bf,
  output logic [LOGN-1:0] a,
  output logic [LOGN-1:0] bb,
  output logic [6:0]      tw
);

  logic [7:0] len;
  logic [7:0] g;
  logic [7:0] off;

  always_comb begin
    if (!mode) begin
      len = 8'd128 >> layer;
      g   = {1'b0, bf} >> (3'd7 - layer);
      tw  = (7'd1 << layer) + g[6:0];
    end else begin
      len = 8'd2 << layer;
      g   = {1'b0, bf} >> ({1'b0, layer} + 4'd1);
      // (128 >> layer) - 1 is the same value as 127 >> layer.
      tw  = (7'd127 >> layer) - g[6:0];
    end
    off = {1'b0, bf} & (len - 8'd1);
    a   = ((g * len) << 1) + off;
    bb  = a + len;
  end

endmodule

// File: rtl/ntt_ctrl.sv
// Sequencer for a full forward or inverse NTT on a single butterfly unit.
// It issues one butterfly per cycle and aligns the write-back addresses with the butterfly output.
//
// state | meaning
// IDLE  | waiting for start; all strobes low
// ISSUE | one read/butterfly per cycle, b = 0..127
// DRAIN | down-count RAM + butterfly latency so the layer's last write lands
// DONE  | one-cycle completion pulse
module ntt_ctrl
  import ntt_pkg::*;
#(
  parameter int RAM_LAT = 1,
  parameter int LAT_CT  = 4,
  parameter int LAT_GS  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] tw_addr,
  output logic       wr_en,
  output logic [7:0] wr_addr_e,
  output logic [7:0] wr_addr_o,
  output logic       ct,
  output logic       pwm
);

  localparam int LAT_MAX = (LAT_GS > LAT_CT) ? LAT_GS : LAT_CT;
  localparam int D_MAX   = RAM_LAT + LAT_MAX;
  localparam int CW      = $clog2(D_MAX + 1);

  ntt_state_t    state, state_n;
  logic [2:0]    layer, layer_n;
  logic [6:0]    bf, bf_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          mode_q, mode_n;
  logic [CW-1:0] d_len;
  logic [CW-1:0] ins;
  logic          issue_n, busy_n;
  logic [7:0]    a_n, bb_n;
  logic [6:0]    tw_n;
  wb_t           wb_in;
  wb_t           pipe [D_MAX];

  assign d_len = mode_q ? CW'(RAM_LAT + LAT_GS) : CW'(RAM_LAT + LAT_CT);
  // The delay line has a fixed tail; a shorter mode enters it further down.
  assign ins   = CW'(D_MAX) - d_len;

  always_comb begin
    state_n = state;
    layer_n = layer;
    bf_n    = bf;
    cnt_n   = cnt;
    mode_n  = mode_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = ISSUE;
          layer_n = 3'd0;
          bf_n    = 7'd0;
          mode_n  = mode;
        end
      end
      ISSUE: begin
        if (bf == 7'(BF_PER_LAYER - 1)) begin
          state_n = DRAIN;
          cnt_n   = d_len - CW'(1);
        end else begin
          bf_n = bf + 7'd1;
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          if (layer < 3'(NUM_LAYERS - 1)) begin
            state_n = ISSUE;
            layer_n = layer + 3'd1;
            bf_n    = 7'd0;
          end else begin
            state_n = DONE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign issue_n = (state_n == ISSUE);
  assign busy_n  = issue_n || (state_n == DRAIN);
  assign wb_in   = {rd_addr_a, rd_addr_b, rd_en};

  ntt_addr_gen u_addr_gen (
    .mode  (mode_n),
    .layer (layer_n),
    .bf    (bf_n),
    .a     (a_n),
    .bb    (bb_n),
    .tw    (tw_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      layer     <= 3'd0;
      bf        <= 7'd0;
      cnt       <= '0;
      mode_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= 8'd0;
      rd_addr_b <= 8'd0;
      tw_addr   <= 7'd0;
      ct        <= 1'b0;
      for (int k = 0; k < D_MAX; k++) pipe[k] <= '0;
    end else begin
      state     <= state_n;
      layer     <= layer_n;
      bf        <= bf_n;
      cnt       <= cnt_n;
      mode_q    <= mode_n;
      busy      <= busy_n;
      done      <= (state_n == DONE);
      rd_en     <= issue_n;
      rd_addr_a <= issue_n ? a_n  : 8'd0;
      rd_addr_b <= issue_n ? bb_n : 8'd0;
      tw_addr   <= issue_n ? tw_n : 7'd0;
      ct        <= busy_n && !mode_n;
      pipe[0]   <= (ins == '0) ? wb_in : '0;
      for (int k = 1; k < D_MAX; k++) begin
        pipe[k] <= (CW'(k) == ins) ? wb_in : pipe[k-1];
      end
    end
  end

  assign wr_en     = pipe[D_MAX-1].v;
  assign wr_addr_e = pipe[D_MAX-1].a;
  assign wr_addr_o = pipe[D_MAX-1].b;
  assign pwm       = 1'b0;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: a cycle-level schedule model built from the reference NTT loop nests,
// compared against every output on every falling edge, plus literal address pins.
module tb_ntt_ctrl;

  localparam int D_FWD = 5;
  localparam int D_INV = 6;

  logic       clk = 1'b0;
  logic       rst, start, mode;
  logic       busy, done, rd_en, wr_en, ct, pwm;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_e, wr_addr_o;
  logic [6:0] tw_addr;

  ntt_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_e (wr_addr_e),
    .wr_addr_o (wr_addr_o),
    .ct        (ct),
    .pwm       (pwm)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc = 0, e0 = 0, wr_cnt = 0, busy_cnt = 0;
  bit active   = 1'b0;
  bit run_mode = 1'b0;

  int tab_a [2][7][128];
  int tab_b [2][7][128];
  int tab_t [2][7][128];

  typedef struct {int md; int l; int b; int a; int bb; int tw;} pin_t;
  pin_t pins [7];

  function automatic int dly(input bit m);
    return m ? D_INV : D_FWD;
  endfunction

  function automatic int period(input bit m);
    return 128 + dly(m);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference Kyber loop nests: forward zeta index counts up from 1, inverse counts down from 127.
  task automatic build_tables();
    int k, l, b;
    k = 1; l = 0;
    for (int len = 128; len >= 2; len = len >> 1) begin
      b = 0;
      for (int st = 0; st < 256; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          tab_a[0][l][b] = j; tab_b[0][l][b] = j + len; tab_t[0][l][b] = k; b++;
        end
        k++;
      end
      l++;
    end
    k = 127; l = 0;
    for (int len = 2; len <= 128; len = len << 1) begin
      b = 0;
      for (int st = 0; st < 256; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          tab_a[1][l][b] = j; tab_b[1][l][b] = j + len; tab_t[1][l][b] = k; b++;
        end
        k--;
      end
      l++;
    end
  endtask

  // Model of start acceptance: a run is accepted only from a cycle after the DONE cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      active = 1'b0;
    end else if (start && (!active || (cyc - 1 - e0) > 7 * period(run_mode))) begin
      active   = 1'b1;
      e0       = cyc;
      run_mode = mode;
      wr_cnt   = 0;
      busy_cnt = 0;
    end
  end

  task automatic cmp_cycle();
    int k, p, t, kw;
    bit e_busy, e_done, e_rd, e_wr;
    p      = period(run_mode);
    t      = 7 * p;
    k      = active ? cyc - e0 : -1;
    kw     = k - dly(run_mode);
    e_busy = active && k >= 0 && k < t;
    e_done = active && k == t;
    e_rd   = e_busy && (k % p) < 128;
    e_wr   = active && kw >= 0 && kw < t && (kw % p) < 128;
    check("busy",  busy,  e_busy);
    check("done",  done,  e_done);
    check("rd_en", rd_en, e_rd);
    check("wr_en", wr_en, e_wr);
    check("ct",    ct,    e_busy && !run_mode);
    check("pwm",   pwm,   0);
    if (e_rd) begin
      check("rd_addr_a", rd_addr_a, tab_a[run_mode][k/p][k%p]);
      check("rd_addr_b", rd_addr_b, tab_b[run_mode][k/p][k%p]);
      check("tw_addr",   tw_addr,   tab_t[run_mode][k/p][k%p]);
      for (int i = 0; i < 7; i++) begin
        if (pins[i].md == int'(run_mode) && k == pins[i].l * p + pins[i].b) begin
          check("pin_a",  rd_addr_a, pins[i].a);
          check("pin_bb", rd_addr_b, pins[i].bb);
          check("pin_tw", tw_addr,   pins[i].tw);
        end
      end
    end
    if (e_wr) begin
      check("wr_addr_e", wr_addr_e, tab_a[run_mode][kw/p][kw%p]);
      check("wr_addr_o", wr_addr_o, tab_b[run_mode][kw/p][kw%p]);
    end
    if (rd_en && wr_en && e_rd && e_wr) check("layer_overlap", kw / p, k / p);
    if (wr_en) wr_cnt++;
    if (busy)  busy_cnt++;
    if (done && active) begin
      check("done_cycle",  k + 1,    run_mode ? 939 : 932);
      check("write_count", wr_cnt,   896);
      check("busy_length", busy_cnt, run_mode ? 938 : 931);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy,  0);
    check({tag, "_done"},  done,  0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_ct"},    ct,    0);
    check({tag, "_pwm"},   pwm,   0);
    check({tag, "_rd_a"},  rd_addr_a, 0);
    check({tag, "_rd_b"},  rd_addr_b, 0);
    check({tag, "_tw"},    tw_addr,   0);
    check({tag, "_wr_e"},  wr_addr_e, 0);
    check({tag, "_wr_o"},  wr_addr_o, 0);
  endtask

  always @(negedge clk) begin
    if (rst) check_all_zero("rst");
    else     cmp_cycle();
  end

  task automatic run_wait(input bit jitter, input bit start_at_done, input int mid_start);
    bit seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (jitter) mode = 1'($urandom_range(0, 1));
        if (mid_start > 0) start = (i == mid_start);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    if (start_at_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    build_tables();
    pins[0] = '{0, 0, 0, 0, 128, 1};
    pins[1] = '{0, 6, 0, 0, 2,   64};
    pins[2] = '{0, 6, 1, 1, 3,   64};
    pins[3] = '{0, 6, 2, 4, 6,   65};
    pins[4] = '{1, 0, 0, 0, 2,   127};
    pins[5] = '{1, 0, 2, 4, 6,   126};
    pins[6] = '{1, 6, 0, 0, 128, 1};

    rst = 1'b1; start = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Forward run with mode jitter, a stray start mid-run and a start during done.
    start = 1'b1; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    run_wait(1'b1, 1'b1, 300);
    repeat (5) @(negedge clk);

    // Inverse run with start held high through the done cycle.
    start = 1'b1; mode = 1'b1;
    run_wait(1'b0, 1'b1, 0);
    repeat (5) @(negedge clk);

    // Forward run interrupted by reset in layer 3, then a fresh inverse run.
    start = 1'b1; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * 133 + 40) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_wait(1'b1, 1'b0, 0);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
